// File: rtl/dm_access_ctrl_if.sv
// dm_access_ctrl_if: handshaked data-memory bus between the MEM-stage sequencer and memory.
// The master drives the request and holds it until bus_ack; the slave acks for one cycle with
// bus_rdata valid alongside.
interface dm_access_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_be,
      output bus_wdata,
      input  bus_ack,
      input  bus_rdata
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_be,
      input  bus_wdata,
      output bus_ack,
      output bus_rdata
   );
endinterface

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage sequencer turning a pipeline load/store into one bus transaction.
// Stalls the pipeline until the bus acks or the wait limit expires, then latches the raw read
// word, access type and addr[1:0] for the load-data extender.
// Build macro DM_ALIGN_CHECK_EN: when defined, misaligned accesses raise exc_adel/exc_ades
// instead of being issued; when undefined the exception outputs are tied low.
module dm_access_ctrl #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             mem_ld,
   input  logic             mem_st,
   input  logic [2:0]       mem_type,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   output logic             stall,
   output logic             done,
   output logic             bus_err,
   output logic [2:0]       ld_type_q,
   output logic [1:0]       addr_low_q,
   output logic [31:0]      rdata_q,
   dm_access_ctrl_if.master bus,
   output logic             exc_adel,
   output logic             exc_ades
);
   // mem_type encoding shared with the load extender
   localparam logic [2:0] WordRead     = 3'd0;
   localparam logic [2:0] ByteSigned   = 3'd1;
   localparam logic [2:0] ByteUnsigned = 3'd2;
   localparam logic [2:0] HalfSigned   = 3'd3;
   localparam logic [2:0] HalfUnsigned = 3'd4;

   localparam int unsigned CntW = $clog2(WAIT_MAX + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(WAIT_MAX - 1);

   typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      ld_type_d;
   logic [1:0]      addr_low_d;
   logic [31:0]     rdata_d;

   logic        req;
   logic        is_half;
   logic        is_byte;
   logic        misaligned;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        bus_req_c;
   logic        bus_we_c;
   logic [31:0] bus_addr_c;
   logic [3:0]  bus_be_c;
   logic [31:0] bus_wdata_c;

   assign req = mem_ld | mem_st;

   // Access width from mem_type; signedness is irrelevant here and unknown codes act as word
   always_comb begin
      is_half = 1'b0;
      is_byte = 1'b0;
      case (mem_type)
         ByteSigned, ByteUnsigned: is_byte = 1'b1;
         HalfSigned, HalfUnsigned: is_half = 1'b1;
         WordRead:                 ;
         default:                  ;
      endcase
   end

   // Lane enables and lane-replicated store data
   always_comb begin
      be    = 4'b1111;
      wdata = mem_wdata;
      if (is_byte) begin
         be    = 4'b0001 << mem_addr[1:0];
         wdata = {4{mem_wdata[7:0]}};
      end else if (is_half) begin
         be    = mem_addr[1] ? 4'b1100 : 4'b0011;
         wdata = {2{mem_wdata[15:0]}};
      end
   end

`ifdef DM_ALIGN_CHECK_EN
   assign misaligned = ((~is_half & ~is_byte) & (|mem_addr[1:0])) | (is_half & mem_addr[0]);
   // Exceptions only fire for a fresh request; no bus transaction is started for it
   assign exc_adel   = (state_q == StIdle) & mem_ld & misaligned;
   assign exc_ades   = (state_q == StIdle) & ~mem_ld & mem_st & misaligned;
`else
   assign misaligned = 1'b0;
   assign exc_adel   = 1'b0;
   assign exc_ades   = 1'b0;
`endif

   // Next state, wait counter, load latches and all handshake outputs
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_type_d   = ld_type_q;
      addr_low_d  = addr_low_q;
      rdata_d     = rdata_q;
      stall       = 1'b0;
      done        = 1'b0;
      bus_err     = 1'b0;
      bus_req_c   = 1'b0;
      bus_we_c    = 1'b0;
      bus_addr_c  = 32'h0;
      bus_be_c    = 4'h0;
      bus_wdata_c = 32'h0;
      unique case (state_q)
         StIdle: begin
            if (req && !misaligned) begin
               stall   = 1'b1;
               state_d = StReq;
               cnt_d   = '0;
            end
         end
         StReq: begin
            stall       = req;
            bus_req_c   = 1'b1;
            // A simultaneous load and store is treated as a load
            bus_we_c    = mem_st & ~mem_ld;
            bus_addr_c  = {mem_addr[31:2], 2'b00};
            bus_be_c    = be;
            bus_wdata_c = wdata;
            if (bus.bus_ack) begin
               state_d = StDone;
               if (mem_ld) begin
                  rdata_d    = bus.bus_rdata;
                  ld_type_d  = mem_type;
                  addr_low_d = mem_addr[1:0];
               end
            end else if (cnt_q == CntLast) begin
               state_d = StErr;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         StErr: begin
            bus_err = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.bus_req   = bus_req_c;
   assign bus.bus_we    = bus_we_c;
   assign bus.bus_addr  = bus_addr_c;
   assign bus.bus_be    = bus_be_c;
   assign bus.bus_wdata = bus_wdata_c;

   // State, counter and extender latches; async reset abandons any transaction in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         ld_type_q  <= 3'h0;
         addr_low_q <= 2'h0;
         rdata_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ld_type_q  <= ld_type_d;
         addr_low_q <= addr_low_d;
         rdata_q    <= rdata_d;
      end
   end
endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: directed and randomized checks of dm_access_ctrl against a
// transaction-level reference model (lane arithmetic, latency from ack position).
module tb_dm_access_ctrl;
   localparam int WaitMax    = 4;
   localparam int CycleLimit = 40;

   localparam logic [2:0] WordRead     = 3'd0;
   localparam logic [2:0] ByteSigned   = 3'd1;
   localparam logic [2:0] ByteUnsigned = 3'd2;
   localparam logic [2:0] HalfSigned   = 3'd3;
   localparam logic [2:0] HalfUnsigned = 3'd4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_ld = 1'b0;
   logic        mem_st = 1'b0;
   logic [2:0]  mem_type = 3'h0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic        stall, done, bus_err, exc_adel, exc_ades;
   logic [2:0]  ld_type_q;
   logic [1:0]  addr_low_q;
   logic [31:0] rdata_q;

   dm_access_ctrl_if bus_if ();

   dm_access_ctrl #(.WAIT_MAX(WaitMax)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mem_ld     (mem_ld),
      .mem_st     (mem_st),
      .mem_type   (mem_type),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .stall      (stall),
      .done       (done),
      .bus_err    (bus_err),
      .ld_type_q  (ld_type_q),
      .addr_low_q (addr_low_q),
      .rdata_q    (rdata_q),
      .bus        (bus_if.master),
      .exc_adel   (exc_adel),
      .exc_ades   (exc_ades)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state of the extender latches
   logic [31:0] m_rdata = 32'h0;
   logic [2:0]  m_type  = 3'h0;
   logic [1:0]  m_alow  = 2'h0;

   // Observations from the last transaction
   int          o_stall, o_done, o_err, o_req, o_post, o_timeout;
   logic        cap_we;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;

   function automatic int model_nbytes(input logic [2:0] t);
      if (t == ByteSigned || t == ByteUnsigned) return 1;
      if (t == HalfSigned || t == HalfUnsigned) return 2;
      return 4;
   endfunction

   // Naturally aligned group of n lanes containing the addressed byte
   function automatic logic [3:0] model_be(input logic [2:0] t, input logic [31:0] a);
      int n   = model_nbytes(t);
      int off = (int'(a[1:0]) / n) * n;
      return 4'(((1 << n) - 1) << off);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] w);
      logic [31:0] r;
      int n = model_nbytes(t);
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = w[(i % n)*8 +: 8];
      return r;
   endfunction

   // Drive one request, play the memory side (ack on the ack_n-th request cycle, 0 = never)
   // and record what the DUT did. hold keeps the request asserted afterwards.
   task automatic run_txn(input logic ld, input logic st, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] wd, input int ack_n,
                          input logic [31:0] rd, input bit hold);
      int  req_seen = 0;
      bit  first = 1'b1;
      bit  finished = 1'b0;
      o_stall = 0; o_done = 0; o_err = 0; o_req = 0; o_post = 0; o_timeout = 0;
      cap_we = 1'b0; cap_addr = 32'h0; cap_be = 4'h0; cap_wdata = 32'h0;
      @(negedge clk);
      mem_ld = ld; mem_st = st; mem_type = typ; mem_addr = addr; mem_wdata = wd;
      bus_if.bus_rdata = rd;
      for (int c = 0; c < CycleLimit; c++) begin
         if (c > 0) @(negedge clk);
         bus_if.bus_ack = 1'b0;
         #1;
         if (bus_if.bus_req) begin
            req_seen++;
            if (first) begin
               cap_we = bus_if.bus_we; cap_addr = bus_if.bus_addr;
               cap_be = bus_if.bus_be; cap_wdata = bus_if.bus_wdata;
               first = 1'b0;
            end
            if (req_seen == ack_n) bus_if.bus_ack = 1'b1;
         end
         o_stall += int'(stall); o_done += int'(done); o_err += int'(bus_err);
         o_req += int'(bus_if.bus_req);
         if (done || bus_err) begin
            finished = 1'b1;
            break;
         end
      end
      if (!finished) o_timeout = 1;
      if (!hold) begin
         @(negedge clk);
         mem_ld = 1'b0; mem_st = 1'b0; bus_if.bus_ack = 1'b0;
         #1;
         o_post = int'(done) + int'(bus_err) + int'(bus_if.bus_req);
      end
   endtask

   task automatic test_reset();
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({stall, done, bus_err, bus_if.bus_req, exc_adel, exc_ades} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b want 000000",
                  {stall, done, bus_err, bus_if.bus_req, exc_adel, exc_ades});
      end
      checks++;
      if ({rdata_q, ld_type_q, addr_low_q} !== 37'h0) begin
         errors++;
         $display("FAIL reset_latch got %h/%h/%h want 0", rdata_q, ld_type_q, addr_low_q);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_load_word();
      run_txn(1'b1, 1'b0, WordRead, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
      m_rdata = 32'hDEAD_BEEF; m_type = WordRead; m_alow = 2'b00;
      checks++;
      if (o_timeout !== 0 || o_done !== 1 || o_err !== 0 || o_post !== 0) begin
         errors++;
         $display("FAIL lw_done got to=%0d done=%0d err=%0d post=%0d want 0 1 0 0",
                  o_timeout, o_done, o_err, o_post);
      end
      checks++;
      if (o_stall !== 4 || o_req !== 3) begin
         errors++; $display("FAIL lw_latency got stall=%0d req=%0d want 4 3", o_stall, o_req);
      end
      checks++;
      if (cap_addr !== 32'h0000_1004 || cap_be !== 4'b1111 || cap_we !== 1'b0) begin
         errors++;
         $display("FAIL lw_bus got %h %b %b want 00001004 1111 0", cap_addr, cap_be, cap_we);
      end
      checks++;
      if (rdata_q !== m_rdata || addr_low_q !== m_alow || ld_type_q !== m_type) begin
         errors++;
         $display("FAIL lw_latch got %h %b %0d want %h %b %0d", rdata_q, addr_low_q,
                  ld_type_q, m_rdata, m_alow, m_type);
      end
   endtask

   task automatic test_store_byte();
      run_txn(1'b0, 1'b1, ByteUnsigned, 32'h0000_2003, 32'h0000_00A5, 1, 32'h1357_9BDF, 1'b0);
      checks++;
      if (cap_we !== 1'b1 || cap_addr !== 32'h0000_2000 || cap_be !== 4'b1000) begin
         errors++;
         $display("FAIL sb_bus got %b %h %b want 1 00002000 1000", cap_we, cap_addr, cap_be);
      end
      checks++;
      if (cap_wdata !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", cap_wdata);
      end
      checks++;
      if (o_done !== 1 || o_stall !== 2) begin
         errors++; $display("FAIL sb_done got done=%0d stall=%0d want 1 2", o_done, o_stall);
      end
      checks++;
      if (rdata_q !== m_rdata || addr_low_q !== m_alow || ld_type_q !== m_type) begin
         errors++;
         $display("FAIL sb_latch got %h %b %0d want %h %b %0d", rdata_q, addr_low_q,
                  ld_type_q, m_rdata, m_alow, m_type);
      end
   endtask

   task automatic test_load_half();
      run_txn(1'b1, 1'b0, HalfUnsigned, 32'h0000_2002, 32'h0, 2, 32'hBEEF_1234, 1'b0);
      m_rdata = 32'hBEEF_1234; m_type = HalfUnsigned; m_alow = 2'b10;
      checks++;
      if (cap_be !== 4'b1100 || o_done !== 1) begin
         errors++; $display("FAIL lhu_be got %b done=%0d want 1100 1", cap_be, o_done);
      end
      checks++;
      if (rdata_q !== m_rdata || addr_low_q !== m_alow || ld_type_q !== m_type) begin
         errors++;
         $display("FAIL lhu_latch got %h %b %0d want %h %b %0d", rdata_q, addr_low_q,
                  ld_type_q, m_rdata, m_alow, m_type);
      end
   endtask

   task automatic test_timeout();
      run_txn(1'b1, 1'b0, WordRead, 32'h0000_4000, 32'h0, 0, 32'h0BAD_0BAD, 1'b0);
      checks++;
      if (o_timeout !== 0 || o_err !== 1 || o_done !== 0 || o_post !== 0) begin
         errors++;
         $display("FAIL to_err got to=%0d err=%0d done=%0d post=%0d want 0 1 0 0",
                  o_timeout, o_err, o_done, o_post);
      end
      checks++;
      if (o_req !== WaitMax || o_stall !== WaitMax + 1) begin
         errors++;
         $display("FAIL to_len got req=%0d stall=%0d want %0d %0d", o_req, o_stall, WaitMax,
                  WaitMax + 1);
      end
      checks++;
      if (rdata_q !== m_rdata) begin
         errors++; $display("FAIL to_latch got %h want %h", rdata_q, m_rdata);
      end
      // Ack on the last allowed cycle wins over the abort
      run_txn(1'b1, 1'b0, WordRead, 32'h0000_4008, 32'h0, WaitMax, 32'h4444_0004, 1'b0);
      m_rdata = 32'h4444_0004; m_type = WordRead; m_alow = 2'b00;
      checks++;
      if (o_done !== 1 || o_err !== 0 || o_req !== WaitMax || rdata_q !== m_rdata) begin
         errors++;
         $display("FAIL to_lastack got done=%0d err=%0d req=%0d rd=%h want 1 0 %0d %h",
                  o_done, o_err, o_req, rdata_q, WaitMax, m_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      @(negedge clk);
      mem_ld = 1'b1; mem_st = 1'b0; mem_type = WordRead; mem_addr = 32'h0000_3000;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'hCAFE_F00D;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (bus_if.bus_req !== 1'b1) begin
         errors++; $display("FAIL rst_pre got bus_req=%b want 1", bus_if.bus_req);
      end
      reset_n = 1'b0; mem_ld = 1'b0;
      #1;
      checks++;
      if (bus_if.bus_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || bus_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_async got req=%b stall=%b done=%b err=%b want 0 0 0 0",
                  bus_if.bus_req, stall, done, bus_err);
      end
      checks++;
      if ({rdata_q, ld_type_q, addr_low_q} !== 37'h0) begin
         errors++;
         $display("FAIL rst_latch got %h/%h/%h want 0", rdata_q, ld_type_q, addr_low_q);
      end
      m_rdata = 32'h0; m_type = 3'h0; m_alow = 2'h0;
      @(negedge clk);
      bus_if.bus_ack = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         bad += int'(done) + int'(bus_err) + int'(bus_if.bus_req) + int'(stall);
      end
      checks++;
      if (bad !== 0 || rdata_q !== 32'h0) begin
         errors++; $display("FAIL rst_ack got activity=%0d rd=%h want 0 0", bad, rdata_q);
      end
   endtask

   task automatic test_misaligned();
`ifdef DM_ALIGN_CHECK_EN
      int seen_req = 0;
      @(negedge clk);
      mem_ld = 1'b1; mem_st = 1'b0; mem_type = WordRead; mem_addr = 32'h0000_1002;
      #1;
      checks++;
      if (exc_adel !== 1'b1 || exc_ades !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL mis_lw got adel=%b ades=%b stall=%b want 1 0 0", exc_adel, exc_ades,
                  stall);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         seen_req += int'(bus_if.bus_req);
      end
      checks++;
      if (seen_req !== 0) begin
         errors++; $display("FAIL mis_noreq got %0d want 0", seen_req);
      end
      mem_ld = 1'b0; mem_st = 1'b1; mem_type = HalfSigned; mem_addr = 32'h0000_1001;
      #1;
      checks++;
      if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL mis_sh got ades=%b adel=%b stall=%b want 1 0 0", exc_ades, exc_adel,
                  stall);
      end
      @(negedge clk);
      mem_st = 1'b0;
`else
      run_txn(1'b1, 1'b0, WordRead, 32'h0000_1002, 32'h0, 1, 32'h7777_1002, 1'b0);
      m_rdata = 32'h7777_1002; m_type = WordRead; m_alow = 2'b10;
      checks++;
      if (cap_addr !== 32'h0000_1000 || cap_be !== 4'b1111 || o_done !== 1) begin
         errors++;
         $display("FAIL mis_lw got %h %b done=%0d want 00001000 1111 1", cap_addr, cap_be,
                  o_done);
      end
      checks++;
      if (addr_low_q !== m_alow || rdata_q !== m_rdata || exc_adel !== 1'b0) begin
         errors++;
         $display("FAIL mis_latch got %b %h adel=%b want %b %h 0", addr_low_q, rdata_q,
                  exc_adel, m_alow, m_rdata);
      end
`endif
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 1'b0, ByteSigned, 32'h0000_5001, 32'h0, 1, 32'h1111_2222, 1'b1);
      m_rdata = 32'h1111_2222; m_type = ByteSigned; m_alow = 2'b01;
      checks++;
      if (o_done !== 1 || rdata_q !== m_rdata || cap_be !== 4'b0010) begin
         errors++;
         $display("FAIL b2b_first got done=%0d rd=%h be=%b want 1 %h 0010", o_done, rdata_q,
                  cap_be, m_rdata);
      end
      // Request still held in IDLE: counts as the next instruction
      run_txn(1'b1, 1'b0, ByteSigned, 32'h0000_5001, 32'h0, 2, 32'h3333_4444, 1'b0);
      m_rdata = 32'h3333_4444;
      checks++;
      if (o_done !== 1 || o_stall !== 3 || rdata_q !== m_rdata) begin
         errors++;
         $display("FAIL b2b_second got done=%0d stall=%0d rd=%h want 1 3 %h", o_done,
                  o_stall, rdata_q, m_rdata);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         logic        ld, st;
         logic [2:0]  typ;
         logic [31:0] addr, wd, rd;
         int          ack_n, exp_req;
         bit          ok;
         ld    = 1'($urandom_range(0, 1));
         st    = ld ? 1'($urandom_range(0, 1)) : 1'b1;
         typ   = 3'($urandom_range(0, 7));
         addr  = $urandom;
         wd    = $urandom;
         rd    = $urandom;
         ack_n = int'($urandom_range(0, WaitMax + 1));
`ifdef DM_ALIGN_CHECK_EN
         addr = addr & ~(32'(model_nbytes(typ)) - 32'd1);
`endif
         run_txn(ld, st, typ, addr, wd, ack_n, rd, 1'b0);
         ok      = (ack_n >= 1) && (ack_n <= WaitMax);
         exp_req = ok ? ack_n : WaitMax;
         if (ok && ld) begin
            m_rdata = rd; m_type = typ; m_alow = addr[1:0];
         end
         checks++;
         if (o_timeout !== 0 || o_done !== int'(ok) || o_err !== int'(!ok) || o_post !== 0) begin
            errors++;
            $display("FAIL rnd_end k=%0d got done=%0d err=%0d post=%0d want %0d %0d 0", k,
                     o_done, o_err, o_post, int'(ok), int'(!ok));
         end
         checks++;
         if (o_req !== exp_req || o_stall !== exp_req + 1) begin
            errors++;
            $display("FAIL rnd_len k=%0d got req=%0d stall=%0d want %0d %0d", k, o_req,
                     o_stall, exp_req, exp_req + 1);
         end
         checks++;
         if (cap_we !== (st & ~ld) || cap_addr !== {addr[31:2], 2'b00} ||
             cap_be !== model_be(typ, addr) || cap_wdata !== model_wdata(typ, wd)) begin
            errors++;
            $display("FAIL rnd_bus k=%0d got %b %h %b %h want %b %h %b %h", k, cap_we,
                     cap_addr, cap_be, cap_wdata, st & ~ld, {addr[31:2], 2'b00},
                     model_be(typ, addr), model_wdata(typ, wd));
         end
         checks++;
         if (rdata_q !== m_rdata || ld_type_q !== m_type || addr_low_q !== m_alow) begin
            errors++;
            $display("FAIL rnd_latch k=%0d got %h %0d %b want %h %0d %b", k, rdata_q,
                     ld_type_q, addr_low_q, m_rdata, m_type, m_alow);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_store_byte();
      test_load_half();
      test_timeout();
      test_reset_mid();
      test_misaligned();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end
endmodule
